conv_seq_ctrl: RTL and testbench
================================

Name: conv_seq_ctrl

Overview:
- Instruction sequencer for the systolic-array core. It generates the 64-bit `inst` word that runs one full 3x3 convolution tile, all kij passes.
- Activations and weights are already resident in xmem. Per kij it loads weights into L0, then into the PEs, streams activations, and drains OFIFO into psum SRAM with on-the-fly output-index mapping.
- It sits between the host/bench and `core`, and replaces the hand-sequenced instruction stimulus.

Parameters:
- `col`, 8, PE columns (weight words per kij).
- `row`, 8, PE rows.
- `len_kij`, 9, kernel positions (3x3).
- `len_nij`, 36, input pixels (6x6).
- `iw`, 6, input feature-map width.
- `ow`, 4, output feature-map width (iw-2).
- `w_base`, 1024, xmem address of kij0 weights; kij k at w_base + k*col.
- `gap_cyc`, 10, idle cycles between kernel load and execute.
- `drain_max`, 32, max drain cycles after execute before timeout.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  sync active-high reset.
- `start`  in  1  pulse; begin tile when idle.
- `ofifo_valid`  in  1  full OFIFO row available.
- `inst`  out  64  core instruction word, registered.
- `busy`  out  1  high from accepted start until done.
- `done`  out  1  one-cycle pulse at tile completion.
- `err_timeout`  out  1  sticky; drain exceeded drain_max; cleared by reset or start.
- `kij_idx`  out  4  current kernel position.

Behaviour:
- `inst` bit map:
  - [0] load, [1] execute, [2] l0_wr, [3] l0_rd, [4] ififo_rd, [5] ififo_wr, [6] ofifo_rd.
  - [17:7] A_xmem, [18] WEN_xmem, [19] CEN_xmem.
  - [30:20] A_pmem, [31] WEN_pmem, [32] CEN_pmem.
  - [33] acc, [34] sfu_passthrough, [35] REN_pmem.
  - [62:36] 0, [63] debug = 0.
- Memory enables are active-low; WEN=0 means write.
- IDLE word: CEN_xmem=1, WEN_xmem=1, CEN_pmem=1, WEN_pmem=1, all other bits 0.
- Reset: state IDLE, inst = IDLE word, busy=0, done=0, err_timeout=0, kij_idx=0. Reset mid-operation aborts immediately; no partial writes after the reset cycle.
- All outputs are registered. `start` sampled at cycle N gives the first non-idle inst at N+1. `start` while busy is ignored.
- FSM: IDLE -> WL0 -> KLOAD -> GAP -> EXEC -> DRAIN -> (NEXT_KIJ -> WL0 | FIN) -> IDLE.
- WL0, col+1 cycles:
  - CEN_xmem=0, WEN_xmem=1, A_xmem = w_base + kij*col + min(t, col-1).
  - l0_wr=1 from t=1 (one-cycle SRAM read latency).
- KLOAD, col+row+1 cycles: l0_rd=1 every cycle; load=1 from the second cycle.
- GAP: gap_cyc cycles of the IDLE word.
- EXEC, len_nij cycles: CEN_xmem=0, WEN_xmem=1, A_xmem=t, l0_wr=1, l0_rd=1, execute=1.
- OFIFO service, in EXEC and DRAIN only. Each cycle `ofifo_valid`=1 and rd_cnt < len_nij:
  - Drive ofifo_rd=1 and increment rd_cnt (0..len_nij).
  - Output index from nij = rd_cnt: x = nij%iw, y = nij/iw, ox = x - kij%3, oy = y - kij/3.
  - If 0<=ox<ow and 0<=oy<ow: CEN_pmem=0, WEN_pmem=0, A_pmem = oy*ow+ox.
  - Otherwise pmem stays disabled (CEN=1), but ofifo_rd=1 still pops the row.
  - kij==0: sfu_passthrough=1, acc=0. kij>0: sfu_passthrough=0, acc=1.
  - ofifo_valid is ignored outside EXEC/DRAIN, and once rd_cnt==len_nij.
- DRAIN exit: rd_cnt==len_nij goes to NEXT_KIJ or FIN.
  - If the drain cycle counter reaches drain_max first: set err_timeout and go to NEXT_KIJ anyway.
- NEXT_KIJ: one cycle; kij_idx++, rd_cnt=0.
- FIN: kij_idx == len_kij-1 complete; done=1 for one cycle, busy=0, kij_idx=0.
- Arithmetic: the onij signed compare uses a 5-bit signed ox/oy. A_pmem is zero-extended to 11 bits.

Decomposition:
- Shared package `core_pkg`:
  - Inst bit-position localparams (INST_LOAD..INST_DEBUG).
  - IDLE_INST constant.
  - FSM state enum.
  - Helper function onij_map(nij, kij) -> {valid, addr}.
- One sub-module: `onij_mapper`, combinational div/mod (or running x/y counters), kept separate so it can be unit-tested.

Test Plan:
- Reset held 3 cycles then released, no start -> inst == IDLE word (bit19=1, bit18=1, bit32=1, bit31=1, rest 0), busy=0 indefinitely.
- start pulse, ofifo_valid tied low -> WL0 A_xmem 1024..1031 with l0_wr from the 2nd cycle. KLOAD 17 cycles with load in the last 16. EXEC A_xmem 0..35 with execute=1. Timeout after 32 drain cycles: err_timeout=1, kij_idx 0->1.
- kij=0 pass with ofifo_valid asserted 36 times -> 16 pmem writes at A_pmem 0..15. nij 0..3 -> addr 0..3; nij 4,5 -> CEN_pmem=1. Each write has passthrough=1, acc=0.
- kij=4 (kx=1, ky=1) -> nij=7 maps to addr 0, nij=28 maps to addr 15; acc=1, passthrough=0.
- Full 9-kij run with a behavioural core model -> 9*16 = 144 pmem writes total, then a single done pulse and busy falls in the same cycle.
- Reset asserted mid-EXEC of kij=3 -> next cycle inst = IDLE word, kij_idx=0. A following start reruns from kij=0.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the convolution instruction sequencer.
//   - tile geometry and timing constants
//   - bit positions of the 64-bit core instruction word and its idle value
//   - sequencer FSM state encoding
//   - onij_map(): maps an OFIFO row index (nij) at kernel position kij to a
//     psum address, flagging rows that fall outside the output map
package core_pkg;

    localparam int COL       = 8;
    localparam int ROW       = 8;
    localparam int LEN_KIJ   = 9;
    localparam int LEN_NIJ   = 36;
    localparam int IW        = 6;
    localparam int OW        = 4;
    localparam int W_BASE    = 1024;
    localparam int GAP_CYC   = 10;
    localparam int DRAIN_MAX = 32;
    localparam int ADDR_W    = 11;

    localparam int INST_LOAD     = 0;
    localparam int INST_EXECUTE  = 1;
    localparam int INST_L0_WR    = 2;
    localparam int INST_L0_RD    = 3;
    localparam int INST_IFIFO_RD = 4;
    localparam int INST_IFIFO_WR = 5;
    localparam int INST_OFIFO_RD = 6;
    localparam int INST_A_XMEM   = 7;   // [17:7]
    localparam int INST_WEN_XMEM = 18;
    localparam int INST_CEN_XMEM = 19;
    localparam int INST_A_PMEM   = 20;  // [30:20]
    localparam int INST_WEN_PMEM = 31;
    localparam int INST_CEN_PMEM = 32;
    localparam int INST_ACC      = 33;
    localparam int INST_SFU_PT   = 34;
    localparam int INST_REN_PMEM = 35;
    localparam int INST_DEBUG    = 63;

    // Both memories deselected and in read mode (enables are active-low).
    localparam logic [63:0] IDLE_INST = 64'h0000_0001_800C_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WL0,
        ST_KLOAD,
        ST_GAP,
        ST_EXEC,
        ST_DRAIN,
        ST_NEXT_KIJ,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } onij_t;

    // Output pixel = input pixel shifted back by the kernel offset. The
    // shift can go negative, so the compare is done on 5-bit signed values.
    function automatic onij_t onij_map(input logic [5:0] nij, input logic [3:0] kij);
        logic [3:0]        x;
        logic [3:0]        y;
        logic [1:0]        kx;
        logic [1:0]        ky;
        logic signed [4:0] ox;
        logic signed [4:0] oy;
        onij_t             r;
        x  = 4'(nij % 6'(IW));
        y  = 4'(nij / 6'(IW));
        kx = 2'(kij % 4'd3);
        ky = 2'(kij / 4'd3);
        ox = $signed({1'b0, x}) - $signed({3'b000, kx});
        oy = $signed({1'b0, y}) - $signed({3'b000, ky});
        r.valid = (ox >= 5'sd0) && (ox < $signed(5'(OW))) &&
                  (oy >= 5'sd0) && (oy < $signed(5'(OW)));
        r.addr  = r.valid ? (ADDR_W'(oy[3:0]) * ADDR_W'(OW) + ADDR_W'(ox[3:0]))
                          : '0;
        return r;
    endfunction

endpackage

// File: rtl/onij_mapper.sv
// onij_mapper: combinational OFIFO-row to psum-address mapper.
//   nij_i   : OFIFO row index (input pixel, 0..35)
//   kij_i   : kernel position (0..8)
//   valid_o : row lands inside the 4x4 output map
//   addr_o  : psum SRAM address (oy*ow + ox), zero when not valid
module onij_mapper
    import core_pkg::*;
(
    input  logic [5:0]        nij_i,
    input  logic [3:0]        kij_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o
);

    onij_t map;

    assign map     = onij_map(nij_i, kij_i);
    assign valid_o = map.valid;
    assign addr_o  = map.addr;

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: instruction sequencer for one 3x3 convolution tile.
// For each kernel position it reads weights from xmem into L0, loads them
// into the PEs, streams activations, and drains OFIFO rows into psum SRAM.
//   clk, reset  : clock, synchronous active-high reset
//   start       : pulse, begins a tile when idle
//   ofifo_valid : a full OFIFO row is available
//   inst        : registered 64-bit core instruction word
//   busy        : tile in progress
//   done        : one-cycle pulse at tile completion
//   err_timeout : sticky, a drain ran out of cycles
//   kij_idx     : current kernel position
module conv_seq_ctrl
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [63:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic [3:0]  kij_idx
);

    state_t            state_q, state_d;
    logic [5:0]        t_q, t_d;            // cycles spent in current state
    logic [3:0]        kij_q, kij_d;
    logic [5:0]        rd_cnt_q, rd_cnt_d;  // OFIFO rows popped this kij
    logic [63:0]       inst_q, inst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic              rd_fire;
    logic              drain_done;
    logic              drain_tmo;
    logic              last_kij;
    logic              map_valid;
    logic [ADDR_W-1:0] map_addr;
    logic [ADDR_W-1:0] wl0_addr;

    assign accept     = (state_q == ST_IDLE) && start;
    assign rd_fire    = ((state_q == ST_EXEC) || (state_q == ST_DRAIN)) &&
                        ofifo_valid && (rd_cnt_q < 6'(LEN_NIJ));
    assign drain_done = (rd_cnt_q == 6'(LEN_NIJ));
    assign drain_tmo  = (state_q == ST_DRAIN) && !drain_done &&
                        (t_q == 6'(DRAIN_MAX-1));
    assign last_kij   = (kij_q == 4'(LEN_KIJ-1));

    // The popped row is mapped with the values current when ofifo_valid is
    // sampled; the resulting write lands in the next registered word.
    onij_mapper u_map (
        .nij_i   (rd_cnt_q),
        .kij_i   (kij_q),
        .valid_o (map_valid),
        .addr_o  (map_addr)
    );

    // The word is built from next-state values so inst lines up with state.
    // The address holds at the last weight for the extra read-latency cycle.
    assign wl0_addr = ADDR_W'(W_BASE) + ADDR_W'(kij_d) * ADDR_W'(COL) +
                      ((t_d > 6'(COL-1)) ? ADDR_W'(COL-1) : ADDR_W'(t_d));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            t_q      <= '0;
            kij_q    <= '0;
            rd_cnt_q <= '0;
            inst_q   <= IDLE_INST;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            kij_q    <= kij_d;
            rd_cnt_q <= rd_cnt_d;
            inst_q   <= inst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start)                     state_d = ST_WL0;
            ST_WL0:      if (t_q == 6'(COL))            state_d = ST_KLOAD;
            ST_KLOAD:    if (t_q == 6'(COL+ROW))        state_d = ST_GAP;
            ST_GAP:      if (t_q == 6'(GAP_CYC-1))      state_d = ST_EXEC;
            ST_EXEC:     if (t_q == 6'(LEN_NIJ-1))      state_d = ST_DRAIN;
            ST_DRAIN:    if (drain_done || drain_tmo)
                             state_d = last_kij ? ST_FIN : ST_NEXT_KIJ;
            ST_NEXT_KIJ: state_d = ST_WL0;
            ST_FIN:      state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        t_d = (state_q == ST_IDLE || state_d != state_q) ? 6'd0 : t_q + 6'd1;

        kij_d = kij_q;
        if (accept || state_d == ST_FIN)
            kij_d = 4'd0;
        else if (state_q == ST_NEXT_KIJ)
            kij_d = kij_q + 4'd1;

        rd_cnt_d = rd_cnt_q;
        if (accept || state_q == ST_NEXT_KIJ)
            rd_cnt_d = 6'd0;
        else if (rd_fire)
            rd_cnt_d = rd_cnt_q + 6'd1;

        err_d = err_q;
        if (accept)
            err_d = 1'b0;
        else if (drain_tmo)
            err_d = 1'b1;
    end

    always_comb begin
        inst_d = IDLE_INST;
        case (state_d)
            ST_WL0: begin
                inst_d[INST_CEN_XMEM]            = 1'b0;
                inst_d[INST_A_XMEM +: ADDR_W]    = wl0_addr;
                inst_d[INST_L0_WR]               = (t_d != 6'd0);
            end
            ST_KLOAD: begin
                inst_d[INST_L0_RD]               = 1'b1;
                inst_d[INST_LOAD]                = (t_d != 6'd0);
            end
            ST_EXEC: begin
                inst_d[INST_CEN_XMEM]            = 1'b0;
                inst_d[INST_A_XMEM +: ADDR_W]    = ADDR_W'(t_d);
                inst_d[INST_L0_WR]               = 1'b1;
                inst_d[INST_L0_RD]               = 1'b1;
                inst_d[INST_EXECUTE]             = 1'b1;
            end
            default: ;
        endcase

        // Rows outside the output map are still popped, just not written.
        if (rd_fire) begin
            inst_d[INST_OFIFO_RD] = 1'b1;
            inst_d[INST_ACC]      = (kij_q != 4'd0);
            inst_d[INST_SFU_PT]   = (kij_q == 4'd0);
            if (map_valid) begin
                inst_d[INST_CEN_PMEM]         = 1'b0;
                inst_d[INST_WEN_PMEM]         = 1'b0;
                inst_d[INST_A_PMEM +: ADDR_W] = map_addr;
            end
        end

        busy_d = (state_d != ST_IDLE) && (state_d != ST_FIN);
        done_d = (state_d == ST_FIN);
    end

    assign inst        = inst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign kij_idx     = kij_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Testbench for conv_seq_ctrl: schedule-level reference model of a tile,
// a simple OFIFO occupancy model of the core, and per-cycle checks.
module tb_conv_seq_ctrl;

    localparam logic [63:0] IDLE_W = 64'h0000_0001_800C_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [63:0] inst;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic [3:0]  kij_idx;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    bit m_err;
    int obs_writes;
    int exp_writes;

    always #5 clk = ~clk;

    conv_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .kij_idx     (kij_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string where, input logic [63:0] e_inst,
                               input logic e_busy, input logic e_done,
                               input logic e_err, input int e_kij);
        chk({where, " inst"}, inst, e_inst);
        chk({where, " busy"}, 64'(busy), 64'(e_busy));
        chk({where, " done"}, 64'(done), 64'(e_done));
        chk({where, " err_timeout"}, 64'(err_timeout), 64'(e_err));
        chk({where, " kij_idx"}, 64'(kij_idx), 64'(e_kij));
        if (inst[32] === 1'b0) obs_writes++;
    endtask

    // Instruction for cycle c of a kij pass, up to the end of execute:
    // 9 weight reads, 17 kernel-load cycles, 10 idle, 36 execute.
    function automatic logic [63:0] fixed_word(input int kij, input int c);
        logic [63:0] w;
        w = IDLE_W;
        if (c < 9) begin
            w[19]   = 1'b0;
            w[17:7] = 11'(1024 + kij * 8 + ((c < 7) ? c : 7));
            w[2]    = (c >= 1);
        end else if (c < 26) begin
            w[3] = 1'b1;
            w[0] = (c >= 10);
        end else if (c >= 36) begin
            w[19]   = 1'b0;
            w[17:7] = 11'(c - 36);
            w[2]    = 1'b1;
            w[3]    = 1'b1;
            w[1]    = 1'b1;
        end
        return w;
    endfunction

    // Pop of OFIFO row nij at kernel position kij: read, plus psum write
    // when the shifted pixel lies in the 4x4 output.
    function automatic logic [63:0] pop_overlay(input logic [63:0] w_in, input int kij, input int nij);
        logic [63:0] w;
        int ox;
        int oy;
        w  = w_in;
        ox = (nij % 6) - (kij % 3);
        oy = (nij / 6) - (kij / 3);
        w[6]  = 1'b1;
        w[33] = (kij != 0);
        w[34] = (kij == 0);
        if (ox >= 0 && ox < 4 && oy >= 0 && oy < 4) begin
            w[32]    = 1'b0;
            w[31]    = 1'b0;
            w[30:20] = 11'(oy * 4 + ox);
        end
        return w;
    endfunction

    // mode 0: OFIFO never valid; 1: random, gated by rows present inside
    // the service window and fully random outside it; 2: valid whenever a
    // row is present.
    function automatic bit pick_valid(input int mode, input int avail, input bit in_window);
        if (mode == 0) return 1'b0;
        if (!in_window) return (mode == 1) ? bit'($urandom_range(0, 1)) : 1'b0;
        if (mode == 2) return (avail > 0);
        return (avail > 0) && ($urandom_range(0, 3) != 0);
    endfunction

    task automatic run_tile(input int tile, input int mode, input int abort_kij,
                            input int abort_c, input bit noise);
        int          pops;
        int          avail;
        bit          pend;
        bit          v;
        bit          tmo;
        bit          exit_now;
        logic [63:0] e;
        obs_writes = 0;
        exp_writes = 0;
        start = 1'b1;
        for (int k = 0; k < 9; k++) begin
            pops  = 0;
            avail = 0;
            pend  = 1'b0;
            tmo   = 1'b0;
            for (int c = 0; c < 72; c++) begin
                tick();
                if (k == 0 && c == 0) begin
                    start = 1'b0;
                    m_err = 1'b0;
                end
                e = fixed_word(k, c);
                if (pend) begin
                    e = pop_overlay(e, k, pops);
                    pops++;
                    avail--;
                    if (e[32] == 1'b0) exp_writes++;
                end
                if (c >= 36) avail++;
                check_cycle($sformatf("tile%0d kij%0d cyc%0d", tile, k, c), e, 1'b1, 1'b0, m_err, k);
                if (k == abort_kij && c == abort_c) begin
                    reset = 1'b1;
                    start = 1'b0;
                    ofifo_valid = 1'b0;
                    tick();
                    reset = 1'b0;
                    m_err = 1'b0;
                    check_cycle($sformatf("tile%0d after-reset", tile), IDLE_W, 1'b0, 1'b0, 1'b0, 0);
                    return;
                end
                v = pick_valid(mode, avail, c >= 36);
                ofifo_valid = v;
                pend = v && (c >= 36) && (pops < 36);
                if (noise) start = ($urandom_range(0, 5) == 0);
            end
            for (int d = 0; d < 32; d++) begin
                tick();
                e = IDLE_W;
                if (pend) begin
                    e = pop_overlay(e, k, pops);
                    pops++;
                    avail--;
                    if (e[32] == 1'b0) exp_writes++;
                end
                check_cycle($sformatf("tile%0d kij%0d drain%0d", tile, k, d), e, 1'b1, 1'b0, m_err, k);
                exit_now = (pops == 36) || (d == 31);
                tmo = (pops != 36) && (d == 31);
                v = pick_valid(mode, avail, 1'b1);
                ofifo_valid = v;
                pend = v && (pops < 36);
                if (noise) start = ($urandom_range(0, 5) == 0);
                if (exit_now) break;
            end
            if (tmo) m_err = 1'b1;
            tick();
            e = IDLE_W;
            if (pend) begin
                e = pop_overlay(e, k, pops);
                if (e[32] == 1'b0) exp_writes++;
            end
            if (k < 8)
                check_cycle($sformatf("tile%0d kij%0d next", tile, k), e, 1'b1, 1'b0, m_err, k);
            else
                check_cycle($sformatf("tile%0d fin", tile), e, 1'b0, 1'b1, m_err, 0);
            ofifo_valid = (mode == 1) ? bit'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
        ofifo_valid = 1'b0;
        tick();
        check_cycle($sformatf("tile%0d idle", tile), IDLE_W, 1'b0, 1'b0, m_err, 0);
        if (mode == 2)
            chk($sformatf("tile%0d pmem_writes", tile), 64'(obs_writes), 64'd144);
        else
            chk($sformatf("tile%0d pmem_writes", tile), 64'(obs_writes), 64'(exp_writes));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ofifo_valid = 1'b0;
        m_err = 1'b0;
        obs_writes = 0;
        repeat (3) tick();
        check_cycle("in-reset", IDLE_W, 1'b0, 1'b0, 1'b0, 0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ofifo_valid = bit'($urandom_range(0, 1));
            tick();
            check_cycle($sformatf("idle%0d", i), IDLE_W, 1'b0, 1'b0, 1'b0, 0);
        end
        ofifo_valid = 1'b0;

        // OFIFO silent: every kij drain times out, err_timeout sticks.
        run_tile(0, 0, -1, -1, 1'b0);
        // One row per execute cycle, start pulses while busy must be ignored.
        run_tile(1, 2, -1, -1, 1'b1);
        // Random OFIFO traffic, aborted by reset in the middle of kij 3 execute.
        run_tile(2, 1, 3, 50, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ofifo_valid = 1'b1;
            tick();
            check_cycle($sformatf("post-abort%0d", i), IDLE_W, 1'b0, 1'b0, 1'b0, 0);
        end
        ofifo_valid = 1'b0;
        // Restart after the abort runs from kij 0 again.
        run_tile(3, 1, -1, -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
